// File: rtl/demux_sched_pkg.sv
// Shared constants and state type for the 1:4 burst demultiplexing scheduler.
package demux_sched_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single channel; a load wins over a drain so
// a simultaneous drain and load keeps the slot full with the new word.
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux4_burst_sched.sv
// Burst scheduler routing one valid/ready stream to four channel slots, with the
// channel chosen round-robin or by dest and held for the length of a burst.
module demux4_burst_sched
  import demux_sched_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         dest,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [SEL_W-1:0]         cur_sel,
  output logic                     burst_act
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  sched_state_t     state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] lock_sel;
  logic             lock_rr;
  logic [CNT_W-1:0] beat_cnt;

  logic [SEL_W-1:0] tgt;
  logic             rr_burst;
  logic             acc;
  logic             burst_end;

  // The target only follows mode/dest while idle; a locked burst keeps its channel.
  always_comb begin
    tgt      = lock_sel;
    rr_burst = lock_rr;
    if (state == IDLE) begin
      tgt      = mode ? dest : rr_ptr;
      rr_burst = !mode;
    end
  end

  assign in_ready  = !rst && (!out_valid[tgt] || out_ready[tgt]);
  assign acc       = in_valid && in_ready;
  assign burst_end = acc && (in_last || (beat_cnt == CNT_W'(BURST_LEN - 1)));
  assign cur_sel   = tgt;
  assign burst_act = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_sel <= '0;
      lock_rr  <= 1'b0;
      beat_cnt <= '0;
    end else if (acc) begin
      if (burst_end) begin
        state    <= IDLE;
        beat_cnt <= '0;
        if (rr_burst) begin
          rr_ptr <= tgt + SEL_W'(1);
        end
      end else if (state == IDLE) begin
        state    <= LOCKED;
        lock_sel <= tgt;
        lock_rr  <= !mode;
        beat_cnt <= CNT_W'(1);
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (acc && (tgt == SEL_W'(k))),
      .drain(out_ready[k]),
      .din  (in_data),
      .valid(out_valid[k]),
      .data (out_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_demux4_burst_sched.sv
// Scoreboard bench: each accepted beat is queued with its expected channel and
// retired when that channel's consumer takes it.
module tb_demux4_burst_sched;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [1:0]  dest;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_ready;
  logic [1:0]  cur_sel;
  logic        burst_act;

  int    vectors;
  int    miscompares;
  beat_t expq[$];

  demux4_burst_sched #(
    .DATA_W   (8),
    .BURST_LEN(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .dest     (dest),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .cur_sel  (cur_sel),
    .burst_act(burst_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the beat is taken.
  task automatic applyStimulus(input logic [7:0] d, input logic last, input logic [1:0] ch,
                               input logic expAct, input logic mustReady);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    if (mustReady) checkOutput("no_bubble_ready", 32'(in_ready), 32'd1);
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("cur_sel", 32'(cur_sel), 32'(ch));
      expq.push_back({ch, d});
      @(posedge clk);
      #1;
      checkOutput("lat_valid", 32'(out_valid[ch]), 32'd1);
      checkOutput("lat_data", 32'(out_data[ch*8 +: 8]), 32'(d));
      checkOutput("burst_act", 32'(burst_act), 32'(expAct));
    end
    @(negedge clk);
  endtask

  // Retire beats the consumers take at the coming rising edge.
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < expq.size(); i++)
            if (idx < 0 && expq[i].ch == 2'(k)) idx = i;
          if (idx < 0) begin
            checkOutput("unexpected_beat", 32'(k), 32'hFFFF);
          end else begin
            checkOutput("drain_data", 32'(out_data[k*8 +: 8]), 32'(expq[idx].data));
            expq.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    mode      = 1'b0;
    dest      = 2'd0;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    in_last   = 1'b0;
    out_ready = 4'hF;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_burst_act", 32'(burst_act), 32'd0);
    checkOutput("rst_cur_sel", 32'(cur_sel), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    $display("[TB] round-robin back-to-back bursts");
    for (int i = 0; i < 8; i++)
      applyStimulus(8'(8'h10 + i), 1'b0, 2'(i / 4), (i % 4) != 3, 1'b0);
    in_valid = 1'b0;
    #1;
    checkOutput("rr_after_t1", 32'(cur_sel), 32'd2);
    checkOutput("idle_after_t1", 32'(burst_act), 32'd0);
    @(negedge clk);

    $display("[TB] directed burst, dest changed mid-burst");
    mode = 1'b1;
    dest = 2'd2;
    applyStimulus(8'h20, 1'b0, 2'd2, 1'b1, 1'b0);
    dest = 2'd3;
    applyStimulus(8'h21, 1'b1, 2'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    mode     = 1'b0;
    #1;
    checkOutput("rr_kept_directed", 32'(cur_sel), 32'd2);
    @(negedge clk);
    mode = 1'b1;
    dest = 2'd3;
    applyStimulus(8'h22, 1'b1, 2'd3, 1'b0, 1'b0);
    in_valid = 1'b0;
    mode     = 1'b0;
    #1;
    checkOutput("rr_kept_directed2", 32'(cur_sel), 32'd2);
    @(negedge clk);

    $display("[TB] stalled target channel");
    applyStimulus(8'h30, 1'b1, 2'd2, 1'b0, 1'b0);
    applyStimulus(8'h31, 1'b1, 2'd3, 1'b0, 1'b0);
    out_ready = 4'hE;
    applyStimulus(8'h40, 1'b0, 2'd0, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h41;
    in_last  = 1'b0;
    repeat (3) begin
      #1;
      checkOutput("stall_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_hold_valid", 32'(out_valid[0]), 32'd1);
      checkOutput("stall_hold_data", 32'(out_data[7:0]), 32'h40);
      checkOutput("stall_no_other", 32'(out_valid[3:1]), 32'd0);
      checkOutput("stall_sel", 32'(cur_sel), 32'd0);
      @(negedge clk);
    end
    out_ready = 4'hF;
    applyStimulus(8'h41, 1'b0, 2'd0, 1'b1, 1'b0);
    applyStimulus(8'h42, 1'b0, 2'd0, 1'b1, 1'b0);
    applyStimulus(8'h43, 1'b1, 2'd0, 1'b0, 1'b0);

    $display("[TB] drain and load in the same cycle");
    applyStimulus(8'h50, 1'b0, 2'd1, 1'b1, 1'b0);
    checkOutput("slot_full_before", 32'(out_valid[1]), 32'd1);
    applyStimulus(8'h51, 1'b1, 2'd1, 1'b0, 1'b1);

    $display("[TB] single-beat round-robin bursts with wrap");
    for (int i = 0; i < 7; i++)
      applyStimulus(8'(8'h60 + i), 1'b1, 2'(i + 2), 1'b0, 1'b0);

    $display("[TB] reset in the middle of a locked burst");
    applyStimulus(8'h70, 1'b0, 2'd1, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h71;
    in_last  = 1'b0;
    rst      = 1'b1;
    #1;
    checkOutput("midrst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_burst_act", 32'(burst_act), 32'd0);
    checkOutput("midrst_cur_sel", 32'(cur_sel), 32'd0);
    checkOutput("midrst_ready_hold", 32'(in_ready), 32'd0);
    expq.delete();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("midrst_rr_ptr", 32'(cur_sel), 32'd0);
    @(negedge clk);
    applyStimulus(8'h80, 1'b1, 2'd0, 1'b0, 1'b0);
    in_valid = 1'b0;

    repeat (3) @(negedge clk);
    #4;
    checkOutput("queue_empty", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
